// File: rtl/wb_stage_seq_pkg.sv
// Shared types for the writeback stage: source selects, load funct3 codes and FSM states.
package wb_stage_seq_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned RF_AW_DEF = 5;

    typedef enum logic [1:0] {
        WB_LOAD = 2'b00,
        WB_ALU  = 2'b01,
        WB_LINK = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

    // Byte length of the instruction, used for the link address.
    function automatic logic [2:0] inst_len(input logic is_comp);
        return is_comp ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/wb_stage_seq_if.sv
// Execute-to-writeback bundle: upstream instruction fields, data-memory response, register-file write port.
interface wb_stage_seq_if
    import wb_stage_seq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RF_AW = RF_AW_DEF
);
    logic             flush_i;
    logic             valid_i;
    logic [XLEN-1:0]  PC_i;
    logic             is_comp_i;
    logic [XLEN-1:0]  alu_i;
    logic [XLEN-1:0]  csr_rdata_i;
    logic [RF_AW-1:0] rd_addr_i;
    logic             rf_wen_c;
    logic [1:0]       wb_sel_c;
    logic [2:0]       ld_type_c;
    logic             mem_rvalid_i;
    logic [XLEN-1:0]  mem_rdata_i;
    logic [RF_AW-1:0] rf_waddr_o;
    logic [XLEN-1:0]  rf_wdata_o;
    logic             rf_wen_o;
    logic             stall_o;
    logic             load_fault_o;
    logic             load_misal_o;

    modport master (
        output flush_i, valid_i, PC_i, is_comp_i, alu_i, csr_rdata_i, rd_addr_i,
               rf_wen_c, wb_sel_c, ld_type_c, mem_rvalid_i, mem_rdata_i,
        input  rf_waddr_o, rf_wdata_o, rf_wen_o, stall_o, load_fault_o, load_misal_o
    );

    modport slave (
        input  flush_i, valid_i, PC_i, is_comp_i, alu_i, csr_rdata_i, rd_addr_i,
               rf_wen_c, wb_sel_c, ld_type_c, mem_rvalid_i, mem_rdata_i,
        output rf_waddr_o, rf_wdata_o, rf_wen_o, stall_o, load_fault_o, load_misal_o
    );
endinterface

// File: rtl/wb_stage_seq_load_align.sv
// Load alignment: picks the byte/half addressed by the low address bits and extends it.
module wb_stage_seq_load_align
    import wb_stage_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      ld_type_i,
    output logic [XLEN-1:0] data_o,
    output logic            misal_o
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension; reserved funct3 codes behave as LW.
    always_comb begin
        byte_s  = rdata_i[{off_i, 3'b000} +: 8];
        half_s  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o  = rdata_i;
        misal_o = 1'b0;
        case (ld_type_e'(ld_type_i))
            LD_LB:  data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            LD_LBU: data_o = {{(XLEN-8){1'b0}}, byte_s};
            LD_LH: begin
                data_o  = {{(XLEN-16){half_s[15]}}, half_s};
                misal_o = off_i[0];
            end
            LD_LHU: begin
                data_o  = {{(XLEN-16){1'b0}}, half_s};
                misal_o = off_i[0];
            end
            default: begin
                data_o  = rdata_i;
                misal_o = (off_i != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/wb_stage_seq.sv
// Writeback stage: registers the execute result, waits for load data with a bounded timer,
// and drives the register-file write port combinationally from the stage register.
module wb_stage_seq
    import wb_stage_seq_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int RF_AW        = RF_AW_DEF,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    wb_stage_seq_if.slave bus
);
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(LOAD_TIMEOUT);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    logic             s_valid_q;
    logic [XLEN-1:0]  s_pc_q;
    logic             s_comp_q;
    logic [XLEN-1:0]  s_alu_q;
    logic [XLEN-1:0]  s_csr_q;
    logic [RF_AW-1:0] s_rd_q;
    logic             s_rfwen_q;
    wb_sel_e          s_sel_q;
    logic [2:0]       s_ldt_q;
    wb_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;

    logic [XLEN-1:0]  ld_data_s;
    logic             ld_misal_s;
    logic             is_load_s;
    logic             load_ok_s;
    logic             stall_s;
    logic             fault_s;
    logic             wr_cond_s;
    logic [XLEN-1:0]  link_s;
    logic [XLEN-1:0]  wdata_s;
    logic [RF_AW-1:0] waddr_s;

    wb_stage_seq_load_align #(.XLEN(XLEN)) u_align (
        .rdata_i   (bus.mem_rdata_i),
        .off_i     (s_alu_q[1:0]),
        .ld_type_i (s_ldt_q),
        .data_o    (ld_data_s),
        .misal_o   (ld_misal_s)
    );

    assign is_load_s = s_valid_q && (s_sel_q == WB_LOAD);
    assign load_ok_s = is_load_s && !ld_misal_s;
    assign link_s    = s_pc_q + {{(XLEN-3){1'b0}}, inst_len(s_comp_q)};

    // Stage register, FSM state and timer; flush empties the stage even while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q <= 1'b0;
            s_pc_q    <= {XLEN{1'b0}};
            s_comp_q  <= 1'b0;
            s_alu_q   <= {XLEN{1'b0}};
            s_csr_q   <= {XLEN{1'b0}};
            s_rd_q    <= {RF_AW{1'b0}};
            s_rfwen_q <= 1'b0;
            s_sel_q   <= WB_LOAD;
            s_ldt_q   <= 3'b000;
            state_q   <= IDLE;
            timer_q   <= {TW{1'b0}};
        end else if (bus.flush_i) begin
            s_valid_q <= 1'b0;
            state_q   <= IDLE;
            timer_q   <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (!stall_s) begin
                s_valid_q <= bus.valid_i;
                s_pc_q    <= bus.PC_i;
                s_comp_q  <= bus.is_comp_i;
                s_alu_q   <= bus.alu_i;
                s_csr_q   <= bus.csr_rdata_i;
                s_rd_q    <= bus.rd_addr_i;
                s_rfwen_q <= bus.rf_wen_c;
                s_sel_q   <= wb_sel_e'(bus.wb_sel_c);
                s_ldt_q   <= bus.ld_type_c;
            end
        end
    end

    // Load-wait FSM: stall is raised in the first cycle a load lacks data so upstream holds immediately.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        stall_s = 1'b0;
        fault_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_ok_s && !bus.mem_rvalid_i) begin
                    stall_s = 1'b1;
                    state_d = WAIT;
                    timer_d = TIMER_ONE;
                end else begin
                    state_d = IDLE;
                    timer_d = {TW{1'b0}};
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    state_d = IDLE;
                    timer_d = {TW{1'b0}};
                end else if (timer_q == TIMEOUT_V) begin
                    fault_s = 1'b1;
                    state_d = IDLE;
                    timer_d = {TW{1'b0}};
                end else begin
                    stall_s = 1'b1;
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = {TW{1'b0}};
            end
        endcase
    end

    // Write-source mux; an empty stage presents an all-zero write port.
    always_comb begin
        waddr_s   = {RF_AW{1'b0}};
        wdata_s   = {XLEN{1'b0}};
        wr_cond_s = 1'b0;
        if (s_valid_q) begin
            waddr_s = s_rd_q;
            case (s_sel_q)
                WB_ALU: begin
                    wdata_s   = s_alu_q;
                    wr_cond_s = 1'b1;
                end
                WB_CSR: begin
                    wdata_s   = s_csr_q;
                    wr_cond_s = 1'b1;
                end
                WB_LINK: begin
                    wdata_s   = link_s;
                    wr_cond_s = 1'b1;
                end
                WB_LOAD: begin
                    wdata_s   = ld_data_s;
                    wr_cond_s = load_ok_s && bus.mem_rvalid_i;
                end
                default: begin
                    wdata_s   = s_alu_q;
                    wr_cond_s = 1'b0;
                end
            endcase
        end else begin
            waddr_s   = {RF_AW{1'b0}};
            wdata_s   = {XLEN{1'b0}};
            wr_cond_s = 1'b0;
        end
    end

    assign bus.rf_waddr_o   = waddr_s;
    assign bus.rf_wdata_o   = wdata_s;
    assign bus.rf_wen_o     = s_valid_q && s_rfwen_q && (s_rd_q != {RF_AW{1'b0}}) && wr_cond_s;
    assign bus.stall_o      = stall_s;
    assign bus.load_fault_o = fault_s;
    assign bus.load_misal_o = is_load_s && ld_misal_s;

endmodule

// File: tb/tb_wb_stage_seq.sv
// Bench for wb_stage_seq: table of single-cycle instructions plus hand-written load-wait sequences.
module tb_wb_stage_seq;
    import wb_stage_seq_pkg::*;

    localparam int LT = 5;
    localparam logic [31:0] RD_WORD = 32'h80FF_FF7F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_seq_if #(.XLEN(32), .RF_AW(5)) bus ();

    wb_stage_seq #(.XLEN(32), .RF_AW(5), .LOAD_TIMEOUT(LT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        comp;
        logic [31:0] alu;
        logic [31:0] csr;
        logic [4:0]  rd;
        logic        rfwen;
        logic [1:0]  sel;
        logic [2:0]  ldt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_chk;
        logic        e_misal;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        chk;
        logic        misal;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[21];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic [31:0] pc, logic comp, logic [31:0] alu, logic [31:0] csr,
                                logic [4:0] rd, logic rfwen, logic [1:0] sel, logic [2:0] ldt,
                                logic rvalid, logic [31:0] rdata, logic e_wen, logic [4:0] e_waddr,
                                logic [31:0] e_wdata, logic e_chk, logic e_misal);
        vec_t v;
        v.pc = pc; v.comp = comp; v.alu = alu; v.csr = csr; v.rd = rd; v.rfwen = rfwen;
        v.sel = sel; v.ldt = ldt; v.rvalid = rvalid; v.rdata = rdata; v.e_wen = e_wen;
        v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_chk = e_chk; v.e_misal = e_misal;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic comp, input logic [31:0] alu,
                               input logic [31:0] csr, input logic [4:0] rd, input logic rfwen,
                               input logic [1:0] sel, input logic [2:0] ldt);
        bus.valid_i = 1'b1; bus.PC_i = pc; bus.is_comp_i = comp; bus.alu_i = alu;
        bus.csr_rdata_i = csr; bus.rd_addr_i = rd; bus.rf_wen_c = rfwen;
        bus.wb_sel_c = sel; bus.ld_type_c = ldt;
    endtask

    task automatic idle_upstream();
        bus.valid_i = 1'b0; bus.PC_i = 32'h0; bus.is_comp_i = 1'b0; bus.alu_i = 32'h0;
        bus.csr_rdata_i = 32'h0; bus.rd_addr_i = 5'd0; bus.rf_wen_c = 1'b0;
        bus.wb_sel_c = 2'b00; bus.ld_type_c = 3'b000;
    endtask

    task automatic push(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic chk, input logic misal);
        exp_t e;
        e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.chk = chk; e.misal = misal;
        sb.push_back(e);
    endtask

    task automatic compare_sb(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got output with no expectation queued, required a queued entry", name);
        end else begin
            e = sb.pop_front();
            check({name, ".wen"}, {31'd0, bus.rf_wen_o}, {31'd0, e.wen});
            check({name, ".waddr"}, {27'd0, bus.rf_waddr_o}, {27'd0, e.waddr});
            if (e.chk) check({name, ".wdata"}, bus.rf_wdata_o, e.wdata);
            check({name, ".misal"}, {31'd0, bus.load_misal_o}, {31'd0, e.misal});
            check({name, ".fault"}, {31'd0, bus.load_fault_o}, 32'd0);
            check({name, ".stall"}, {31'd0, bus.stall_o}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".wen"}, {31'd0, bus.rf_wen_o}, 32'd0);
        check({name, ".waddr"}, {27'd0, bus.rf_waddr_o}, 32'd0);
        check({name, ".wdata"}, bus.rf_wdata_o, 32'd0);
        check({name, ".stall"}, {31'd0, bus.stall_o}, 32'd0);
        check({name, ".fault"}, {31'd0, bus.load_fault_o}, 32'd0);
        check({name, ".misal"}, {31'd0, bus.load_misal_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sc;
        bit  done;
        vecs[0]  = mk(32'h0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b01, 3'b000, 1'b1, 32'hDEAD0000, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0);
        vecs[1]  = mk(32'h100, 1'b1, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, 3'b000, 1'b0, 32'h0, 1'b1, 5'd1, 32'h102, 1'b1, 1'b0);
        vecs[2]  = mk(32'h100, 1'b0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, 3'b000, 1'b0, 32'h0, 1'b1, 5'd1, 32'h104, 1'b1, 1'b0);
        vecs[3]  = mk(32'hFFFFFFFC, 1'b0, 32'h0, 32'h0, 5'd31, 1'b1, 2'b10, 3'b000, 1'b0, 32'h0, 1'b1, 5'd31, 32'h0, 1'b1, 1'b0);
        vecs[4]  = mk(32'h0, 1'b0, 32'h55, 32'hDEADBEEF, 5'd7, 1'b1, 2'b11, 3'b000, 1'b0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0);
        vecs[5]  = mk(32'h0, 1'b0, 32'h1003, 32'h0, 5'd10, 1'b1, 2'b00, 3'b000, 1'b1, RD_WORD, 1'b1, 5'd10, 32'hFFFFFF80, 1'b1, 1'b0);
        vecs[6]  = mk(32'h0, 1'b0, 32'h1002, 32'h0, 5'd11, 1'b1, 2'b00, 3'b101, 1'b1, RD_WORD, 1'b1, 5'd11, 32'h000080FF, 1'b1, 1'b0);
        vecs[7]  = mk(32'h0, 1'b0, 32'h1001, 32'h0, 5'd12, 1'b1, 2'b00, 3'b001, 1'b1, RD_WORD, 1'b0, 5'd12, 32'h0, 1'b0, 1'b1);
        vecs[8]  = mk(32'h0, 1'b0, 32'h1000, 32'h0, 5'd13, 1'b1, 2'b00, 3'b010, 1'b1, RD_WORD, 1'b1, 5'd13, 32'h80FFFF7F, 1'b1, 1'b0);
        vecs[9]  = mk(32'h0, 1'b0, 32'h1000, 32'h0, 5'd14, 1'b1, 2'b00, 3'b100, 1'b1, RD_WORD, 1'b1, 5'd14, 32'h0000007F, 1'b1, 1'b0);
        vecs[10] = mk(32'h0, 1'b0, 32'h1001, 32'h0, 5'd15, 1'b1, 2'b00, 3'b000, 1'b1, RD_WORD, 1'b1, 5'd15, 32'hFFFFFFFF, 1'b1, 1'b0);
        vecs[11] = mk(32'h0, 1'b0, 32'h1000, 32'h0, 5'd16, 1'b1, 2'b00, 3'b001, 1'b1, RD_WORD, 1'b1, 5'd16, 32'hFFFFFF7F, 1'b1, 1'b0);
        vecs[12] = mk(32'h0, 1'b0, 32'h1000, 32'h0, 5'd17, 1'b1, 2'b00, 3'b101, 1'b1, RD_WORD, 1'b1, 5'd17, 32'h0000FF7F, 1'b1, 1'b0);
        vecs[13] = mk(32'h0, 1'b0, 32'h1002, 32'h0, 5'd18, 1'b1, 2'b00, 3'b001, 1'b1, RD_WORD, 1'b1, 5'd18, 32'hFFFF80FF, 1'b1, 1'b0);
        vecs[14] = mk(32'h0, 1'b0, 32'h1002, 32'h0, 5'd19, 1'b1, 2'b00, 3'b010, 1'b1, RD_WORD, 1'b0, 5'd19, 32'h0, 1'b0, 1'b1);
        vecs[15] = mk(32'h0, 1'b0, 32'h1000, 32'h0, 5'd20, 1'b1, 2'b00, 3'b011, 1'b1, RD_WORD, 1'b1, 5'd20, 32'h80FFFF7F, 1'b1, 1'b0);
        vecs[16] = mk(32'h0, 1'b0, 32'h1001, 32'h0, 5'd21, 1'b1, 2'b00, 3'b110, 1'b1, RD_WORD, 1'b0, 5'd21, 32'h0, 1'b0, 1'b1);
        vecs[17] = mk(32'h0, 1'b0, 32'h5555, 32'h0, 5'd0, 1'b1, 2'b01, 3'b000, 1'b0, 32'h0, 1'b0, 5'd0, 32'h5555, 1'b1, 1'b0);
        vecs[18] = mk(32'h0, 1'b0, 32'h77, 32'h0, 5'd22, 1'b0, 2'b01, 3'b000, 1'b0, 32'h0, 1'b0, 5'd22, 32'h77, 1'b1, 1'b0);
        vecs[19] = mk(32'h0, 1'b0, 32'h1002, 32'h0, 5'd23, 1'b1, 2'b00, 3'b100, 1'b1, RD_WORD, 1'b1, 5'd23, 32'h000000FF, 1'b1, 1'b0);
        vecs[20] = mk(32'h0, 1'b0, 32'h1000, 32'h0, 5'd0, 1'b1, 2'b00, 3'b010, 1'b1, RD_WORD, 1'b0, 5'd0, RD_WORD, 1'b1, 1'b0);

        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = 32'h0;
        idle_upstream();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_all_zero("reset");

        // Table: one instruction per cycle; mem response held through the following edge.
        for (int i = 0; i < 21; i++) begin
            drive_instr(vecs[i].pc, vecs[i].comp, vecs[i].alu, vecs[i].csr, vecs[i].rd,
                        vecs[i].rfwen, vecs[i].sel, vecs[i].ldt);
            push(vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_chk, vecs[i].e_misal);
            @(posedge clk);
            #1 bus.mem_rvalid_i = vecs[i].rvalid;
            bus.mem_rdata_i = vecs[i].rdata;
            #1 compare_sb($sformatf("vec%0d", i));
        end
        idle_upstream();
        @(posedge clk);
        #1 bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
        #1 check_all_zero("empty_stage");

        // Load answered three cycles late; a following ALU op must wait upstream.
        bus.mem_rvalid_i = 1'b0;
        drive_instr(32'h0, 1'b0, 32'h2000, 32'h0, 5'd3, 1'b1, 2'b00, 3'b010);
        push(1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 1'b0);
        @(posedge clk);
        #1 drive_instr(32'h0, 1'b0, 32'h77, 32'h0, 5'd4, 1'b1, 2'b01, 3'b000);
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("late_stall%0d", k), {31'd0, bus.stall_o}, 32'd1);
            check($sformatf("late_nowen%0d", k), {31'd0, bus.rf_wen_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i = 32'hCAFEF00D;
        #1 compare_sb("late_write");
        push(1'b1, 5'd4, 32'h77, 1'b1, 1'b0);
        @(posedge clk);
        #1 idle_upstream();
        bus.mem_rvalid_i = 1'b0;
        #1 compare_sb("held_instr");

        // Load with no response: stall for LT cycles, then a fault pulse without a write.
        drive_instr(32'h0, 1'b0, 32'h3000, 32'h0, 5'd6, 1'b1, 2'b00, 3'b010);
        @(posedge clk);
        #1 idle_upstream();
        sc = 0;
        done = 1'b0;
        for (int k = 0; k < LT + 4 && !done; k++) begin
            #1;
            if (bus.stall_o) begin
                sc++;
                check("to_nowen", {31'd0, bus.rf_wen_o}, 32'd0);
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
                check("to_stall_cycles", sc, LT);
                check("to_fault", {31'd0, bus.load_fault_o}, 32'd1);
                check("to_fault_nowen", {31'd0, bus.rf_wen_o}, 32'd0);
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL to_release: stall still high after %0d cycles, required release", sc);
        end
        @(posedge clk);
        #2 check("to_pulse_end", {31'd0, bus.load_fault_o}, 32'd0);
        check("to_stall_end", {31'd0, bus.stall_o}, 32'd0);

        // Flush while waiting, then a stray response must not write.
        drive_instr(32'h0, 1'b0, 32'h4000, 32'h0, 5'd8, 1'b1, 2'b00, 3'b010);
        @(posedge clk);
        #1 idle_upstream();
        #1 check("fl_stall0", {31'd0, bus.stall_o}, 32'd1);
        @(posedge clk);
        #1 bus.flush_i = 1'b1;
        #1 check("fl_stall1", {31'd0, bus.stall_o}, 32'd1);
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i = 32'h1234_5678;
        #1 check_all_zero("fl_stray");
        @(posedge clk);
        #1 bus.mem_rvalid_i = 1'b0;

        // Reset in the middle of a wait clears everything.
        drive_instr(32'h0, 1'b0, 32'h5000, 32'h0, 5'd9, 1'b1, 2'b00, 3'b010);
        @(posedge clk);
        #1 idle_upstream();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i = 32'h0BAD_0BAD;
        #1 check_all_zero("rst_wait");
        bus.mem_rvalid_i = 1'b0;
        drive_instr(32'h0, 1'b0, 32'hABCD, 32'h0, 5'd2, 1'b1, 2'b01, 3'b000);
        push(1'b1, 5'd2, 32'hABCD, 1'b1, 1'b0);
        @(posedge clk);
        #1 idle_upstream();
        #1 compare_sb("after_rst");

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
